// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter and its tag FIFO.
// Default widths match the top-level parameter defaults (4 requesters, 8-bit data).
package alu_arb_pkg;

  localparam int NUM_REQ_DFLT    = 4;
  localparam int MAX_OUT_DFLT    = 4;
  localparam int DATA_WIDTH_DFLT = 8;
  localparam int SEL_WIDTH_DFLT  = 2;

  localparam int TAG_WIDTH = $clog2(NUM_REQ_DFLT);
  localparam int CNT_WIDTH = $clog2(MAX_OUT_DFLT) + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  typedef struct packed {
    logic [DATA_WIDTH_DFLT-1:0] data_1;
    logic [DATA_WIDTH_DFLT-1:0] data_2;
    logic [SEL_WIDTH_DFLT-1:0]  sel;
  } alu_op_t;

endpackage

// File: rtl/alu_arb_tag_fifo.sv
// In-order FIFO of requester tags for ops issued to the ALU but not yet returned.
// full/empty derive from the registered count, so a pop never frees a slot in its own cycle.
module alu_arb_tag_fifo
  import alu_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DFLT,
  parameter int WIDTH = TAG_WIDTH,
  parameter int CNT_W = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem[rd_ptr_reg];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 2-stage ALU between NUM_REQ requesters; results routed back by tag.
// Define ALU_ARB_HIPRI_EN to give requester 0 absolute priority over the round-robin group.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int SEL_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_1_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_2_i,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  req_sel_i,
  output logic                          alu_valid_o,
  output logic [DATA_WIDTH-1:0]         alu_data_1_o,
  output logic [DATA_WIDTH-1:0]         alu_data_2_o,
  output logic [SEL_WIDTH-1:0]          alu_sel_o,
  input  logic                          alu_valid_i,
  input  logic [DATA_WIDTH:0]           alu_data_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH:0]           rsp_data_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int TW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
`ifdef ALU_ARB_HIPRI_EN
  localparam bit HIPRI = 1'b1;
`else
  localparam bit HIPRI = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] data_1_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_2_arr [NUM_REQ];
  logic [SEL_WIDTH-1:0]  sel_arr    [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_1_arr[gi] = req_data_1_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign data_2_arr[gi] = req_data_2_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sel_arr[gi]    = req_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
    end
  endgenerate

  logic [TW-1:0]         ptr_reg;
  logic                  alu_valid_reg;
  logic [DATA_WIDTH-1:0] alu_data_1_reg;
  logic [DATA_WIDTH-1:0] alu_data_2_reg;
  logic [SEL_WIDTH-1:0]  alu_sel_reg;
  logic [NUM_REQ-1:0]    rsp_valid_reg;
  logic [DATA_WIDTH:0]   rsp_data_reg;
  logic                  err_reg;

  logic [TW-1:0] grant_idx;
  logic [TW-1:0] cand;
  logic          grant_any;
  logic          transfer;
  logic          fifo_full;
  logic          fifo_empty;
  logic [TW-1:0] fifo_dout;
  logic [CW-1:0] fifo_count;

  // Scan ptr+1 .. ptr+NUM_REQ; with high priority, requester 0 preempts and is left out of the scan.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (HIPRI && req_valid_i[0]) begin
      grant_any = 1'b1;
    end else begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = TW'((int'(ptr_reg) + i) % NUM_REQ);
        if (!grant_any && req_valid_i[cand] && !(HIPRI && cand == '0)) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Ready is masked by rst_n so the outputs read zero while reset is asserted.
  assign transfer    = grant_any && !fifo_full && rst_n;
  assign req_ready_o = transfer ? (NUM_REQ'(1) << grant_idx) : '0;

  alu_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (TW),
    .CNT_W (CW)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (transfer),
    .din   (grant_idx),
    .pop   (alu_valid_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg        <= '0;
      alu_valid_reg  <= 1'b0;
      alu_data_1_reg <= '0;
      alu_data_2_reg <= '0;
      alu_sel_reg    <= '0;
      rsp_valid_reg  <= '0;
      rsp_data_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      alu_valid_reg <= transfer;
      if (transfer) begin
        alu_data_1_reg <= data_1_arr[grant_idx];
        alu_data_2_reg <= data_2_arr[grant_idx];
        alu_sel_reg    <= sel_arr[grant_idx];
        if (!(HIPRI && grant_idx == '0)) ptr_reg <= grant_idx;
      end
      rsp_valid_reg <= '0;
      if (alu_valid_i) begin
        if (fifo_empty) begin
          err_reg <= 1'b1;
        end else begin
          rsp_valid_reg <= NUM_REQ'(1) << fifo_dout;
          rsp_data_reg  <= alu_data_i;
        end
      end
    end
  end

  assign alu_valid_o  = alu_valid_reg;
  assign alu_data_1_o = alu_data_1_reg;
  assign alu_data_2_o = alu_data_2_reg;
  assign alu_sel_o    = alu_sel_reg;
  assign rsp_valid_o  = rsp_valid_reg;
  assign rsp_data_o   = rsp_data_reg;
  assign err_o        = err_reg;
  assign busy_o       = (fifo_count != '0) || alu_valid_reg || (rsp_valid_reg != '0);

endmodule
